// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Requester side of the word-addressed data memory port. Turns byte/half/word
//   load and store requests carrying 32-bit byte addresses into single-word
//   memory accesses. Sub-word stores are done as read-modify-write.
//   One request is outstanding at a time. A response is held until the
//   consumer accepts it.
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we, req_size    store flag; size 00 byte, 01 half, 10 word, 11 reserved
//   req_signed          sign-extend sub-word load results
//   req_addr, req_wdata byte address; right-justified store data
//   resp_valid/ready    response handshake
//   resp_rdata          load result (0 for stores and errors)
//   resp_err            misaligned, out-of-range or reserved size
//   mem_addr/we/wdata   word index, write strobe and write data to dataMemory
//   mem_rdata           combinational read data for mem_addr
module mem_access_unit #(
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_we,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Fields kept for the READ stage; the word index lives in mem_addr.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   cur;

  logic        accept;
  logic        req_bad;
  logic        misalign;
  logic        range_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  lane_en;
  logic [31:0] wrep;
  logic [31:0] merged;

  assign req_ready  = (state == IDLE) & ~reset;
  assign mem_we     = (state == WRITE) & ~reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;

  // Request classification on the live request bus.
  assign misalign  = ((req_size == 2'b01) & req_addr[0]) |
                     ((req_size == 2'b10) & (|req_addr[1:0]));
  assign range_err = |(req_addr >> (MEM_ADDR_WIDTH + 2));
  assign req_bad   = (req_size == 2'b11) | misalign | range_err;

  // Load extraction from the word being read this cycle.
  assign ld_byte = mem_rdata[{cur.lane, 3'b000} +: 8];
  assign ld_half = cur.lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (cur.size)
      2'b00:   ld_data = {{24{cur.sgn & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{cur.sgn & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Store merge: replicate the store data across all lanes, then pick
  // per byte lane between the new data and the word just read.
  always_comb begin
    lane_en = 4'b1111;
    wrep    = cur.wdata;
    case (cur.size)
      2'b00: begin
        lane_en = 4'b0001 << cur.lane;
        wrep    = {4{cur.wdata[7:0]}};
      end
      2'b01: begin
        lane_en = cur.lane[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{cur.wdata[15:0]}};
      end
      default: begin
        lane_en = 4'b1111;
        wrep    = cur.wdata;
      end
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = lane_en[i] ? wrep[8*i +: 8] : mem_rdata[8*i +: 8];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                              state_nxt = RESP;
          else if (req_we && (req_size == 2'b10))   state_nxt = WRITE;
          else                                      state_nxt = READ;
        end
      end
      READ:    state_nxt = cur.we ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur.we     <= req_we;
            cur.size   <= req_size;
            cur.sgn    <= req_signed;
            cur.lane   <= req_addr[1:0];
            cur.wdata  <= req_wdata;
            mem_addr   <= req_addr[MEM_ADDR_WIDTH+1:2];
            // Word stores go straight to WRITE with the raw data.
            mem_wdata  <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= req_bad;
          end
        end
        READ: begin
          if (cur.we) mem_wdata  <= merged;
          else        resp_rdata <= ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  // Environment memory (the dataMemory stand-in) and reference model memory.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  mem_access_unit #(.MEM_ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwe;
    logic [9:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One transaction: drive at a negedge, accept at the posedge, then watch
  // negedges until resp_valid (bounded). Returns on the negedge where the
  // response is first visible; resp_ready is left as the caller set it.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nwe, output logic [9:0] wa, output logic [31:0] wd);
    bit done;
    rd = '0; er = 1'b0; lat = -1; nwe = 0; wa = '0; wd = '0; done = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_ready_before_accept actual=0 required=1");
    end
    @(posedge clk);
    for (int n = 1; n <= 8 && !done; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin nwe++; wa = mem_addr; wd = mem_wdata; end
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err; lat = n; done = 1;
      end
    end
  endtask

  // Behavioural reference: plain arithmetic on byte addresses.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er,
                                output int lat, output int nwe);
    logic [31:0] mask, w, val;
    int sh, nbits;
    rd = '0; nwe = 0;
    er = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
         (size == 2'd2 && (addr % 4) != 0) || (addr >= 32'd4096);
    if (er) begin lat = 1; return; end
    nbits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
    sh    = int'(addr % 4) * 8;
    w     = ref_mem[addr / 4];
    if (!we) begin
      val = (w >> sh) & mask;
      if (sgn && nbits < 32 && ((val >> (nbits - 1)) & 32'd1) == 32'd1) val = val | ~mask;
      rd  = val;
      lat = 2;
    end else begin
      ref_mem[addr / 4] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      lat = (size == 2'd2) ? 2 : 3;
      nwe = 1;
    end
  endfunction

  vec_t        vecs [16];
  logic [31:0] rd, erd;
  logic        er, eer;
  int          lat, elat, nwe, enwe;
  logic [9:0]  wa;
  logic [31:0] wd, held;
  int          we_seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 32'h8BAD_F00D;

    //           we    size  sgn   addr          wdata         rdata         err   lat nwe waddr   wdata
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h14,       32'h0,        32'h8BADF00D, 1'b0, 2, 0, 10'd0, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h17,       32'h0,        32'hFFFFFF8B, 1'b0, 2, 0, 10'd0, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h17,       32'h0,        32'h0000008B, 1'b0, 2, 0, 10'd0, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h16,       32'h0,        32'hFFFF8BAD, 1'b0, 2, 0, 10'd0, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h14,       32'h0,        32'h0000F00D, 1'b0, 2, 0, 10'd0, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h14,       32'h0,        32'h0000000D, 1'b0, 2, 0, 10'd0, 32'h0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h15,       32'h123456A5, 32'h0,        1'b0, 3, 1, 10'd5, 32'h8BADA50D};
    vecs[7]  = '{1'b0, 2'd2, 1'b1, 32'h14,       32'h0,        32'h8BADA50D, 1'b0, 2, 0, 10'd0, 32'h0};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h13,       32'h0,        32'h0,        1'b1, 1, 0, 10'd0, 32'h0};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h1000,     32'hDEADBEEF, 32'h0,        1'b1, 1, 0, 10'd0, 32'h0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h14,       32'h0,        32'h0,        1'b1, 1, 0, 10'd0, 32'h0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h16,       32'hABCD1234, 32'h0,        1'b0, 3, 1, 10'd5, 32'h1234A50D};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h18,       32'hCAFEBABE, 32'h0,        1'b0, 2, 1, 10'd6, 32'hCAFEBABE};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h18,       32'h0,        32'hCAFEBABE, 1'b0, 2, 0, 10'd0, 32'h0};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h1A,       32'h0,        32'h0,        1'b1, 1, 0, 10'd0, 32'h0};
    vecs[15] = '{1'b1, 2'd3, 1'b0, 32'h18,       32'h11111111, 32'h0,        1'b1, 1, 0, 10'd0, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready",  {31'b0, req_ready},  32'd1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_resp_err",   {31'b0, resp_err},   32'd0);
    chk("reset_resp_rdata", resp_rdata,          32'd0);
    chk("reset_mem_we",     {31'b0, mem_we},     32'd0);
    chk("reset_mem_addr",   {22'b0, mem_addr},   32'd0);
    chk("reset_mem_wdata",  mem_wdata,           32'd0);

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             rd, er, lat, nwe, wa, wd);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_mem_we_pulses", i), nwe, vecs[i].exp_nwe);
      if (vecs[i].exp_nwe == 1) begin
        chk($sformatf("vec%0d_mem_addr", i), {22'b0, wa}, {22'b0, vecs[i].exp_waddr});
        chk($sformatf("vec%0d_mem_wdata", i), wd, vecs[i].exp_wdata);
      end
    end
    @(negedge clk);
    chk("table_mem5", mem[5], 32'h1234A50D);
    chk("table_mem6", mem[6], 32'hCAFEBABE);

    // Back-pressure: response held while resp_ready is low; requests ignored.
    resp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, er, lat, nwe, wa, wd);
    chk("bp_latency", lat, 2);
    chk("bp_rdata", rd, 32'h1234A50D);
    held = resp_rdata;
    we_seen = 0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
      req_addr = 32'h18; req_wdata = 32'h0;
      @(negedge clk);
      if (mem_we) we_seen++;
      chk($sformatf("bp_resp_valid_%0d", k), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("bp_rdata_stable_%0d", k), resp_rdata, held);
      chk($sformatf("bp_req_ready_%0d", k), {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", {31'b0, resp_valid}, 32'd0);
    chk("bp_released_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_no_write", we_seen, 0);
    chk("bp_mem6_intact", mem[6], 32'hCAFEBABE);

    // Reset during the WRITE cycle of a sub-word store.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_read_no_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    chk("rst_write_we", {31'b0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_we_gated", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mem5_unchanged", mem[5], 32'h1234A50D);
    chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
    chk("rst_resp_rdata", resp_rdata,          32'd0);
    chk("rst_mem_addr",   {22'b0, mem_addr},   32'd0);
    chk("rst_mem_wdata",  mem_wdata,           32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int t = 0; t < 300; t++) begin
      logic        rwe, rsgn;
      logic [1:0]  rsz;
      logic [31:0] raddr, rwd;
      rwe   = 1'($urandom_range(0, 1));
      rsgn  = 1'($urandom_range(0, 1));
      rsz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      raddr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 63));
      rwd   = $urandom;
      model(rwe, rsz, rsgn, raddr, rwd, erd, eer, elat, enwe);
      do_req(rwe, rsz, rsgn, raddr, rwd, rd, er, lat, nwe, wa, wd);
      chk($sformatf("rnd%0d_rdata", t), rd, erd);
      chk($sformatf("rnd%0d_err", t), {31'b0, er}, {31'b0, eer});
      chk($sformatf("rnd%0d_latency", t), lat, elat);
      chk($sformatf("rnd%0d_mem_we_pulses", t), nwe, enwe);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
